pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Parametrised hazard and forwarding controller for the in-order pipeline.
- Tracks in-flight register writers in a DEPTH-entry shift register that mirrors the post-ID stages (entry 1 = EX, entry DEPTH = WB).
- Generates stall, bubble, flush and per-operand forward-select signals.
- Sits beside the IF/ID and ID/EX pipeline registers. Replaces ad-hoc valid handling with a configurable depth, forwarding mode and performance counters.

Parameters:
- ADDR_W, 5: register-index width; index 0 is hardwired zero and never creates a hazard.
- DEPTH, 3: number of tracked stages after ID (2..7).
- FWD_EN, 1: 1 = forward from any stage whose result is ready; 0 = stall on every RAW match.
- LOAD_STAGE, 2: entry index at which load data first becomes forwardable (1..DEPTH).
- CNT_W, 16: width of the saturating performance counters.

Ports:
- sys_clk, in, 1: clock.
- sys_rst, in, 1: synchronous active-low reset.
- id_valid, in, 1: ID holds a real instruction.
- id_rs1, in, ADDR_W: ID source register 1.
- id_rs1_used, in, 1: rs1 is read by the ID instruction.
- id_rs2, in, ADDR_W: ID source register 2.
- id_rs2_used, in, 1: rs2 is read by the ID instruction.
- id_rd, in, ADDR_W: ID destination register.
- id_rd_we, in, 1: ID instruction writes rd.
- id_is_load, in, 1: ID instruction is a load.
- redirect, in, 1: taken branch/jump resolved in EX.
- stall_in, in, 1: external freeze (memory wait).
- stall_if, out, 1: hold PC and IF/ID.
- bubble_ex, out, 1: load a bubble into ID/EX.
- flush_if_id, out, 1: invalidate IF/ID.
- issue, out, 1: ID instruction advances this cycle.
- fwd_rs1, out, SEL_W = clog2(DEPTH+1): 0 = regfile, k = forward from entry k.
- fwd_rs2, out, SEL_W: same encoding as fwd_rs1.
- busy, out, 1: any entry valid.
- stall_cnt, out, CNT_W: cycles with hazard_stall & ~stall_in.
- flush_cnt, out, CNT_W: cycles with flush_if_id.

Behaviour:
- Reset, checked on the sys_clk edge when sys_rst == 0:
  - all entries {valid, rd, we, is_load} cleared; both counters cleared.
  - Outputs are combinational from entries and inputs, so during reset and the cycle after, all outputs are 0 when inputs are idle.
  - Reset mid-operation discards all in-flight entries.
- Match on entry k: valid & we & rd == rs & rs != 0 & rs_used.
  - The lowest k wins (youngest writer); fwd_rsX = that k, else 0.
- Per-operand hazard:
  - FWD_EN = 1: nearest matching entry has is_load and k < LOAD_STAGE.
  - FWD_EN = 0: any match.
  - hazard_stall = id_valid & (hazard_rs1 | hazard_rs2).
  - fwd_rsX is still driven during a hazard; the consumer ignores it while stalled.
  - With FWD_EN = 0, fwd_rsX is always 0.
- Priority, highest first:
  1. stall_in: all entries hold; stall_if = 1; bubble_ex = 0; flush_if_id = 0; issue = 0. A redirect must be held by its source until stall_in deasserts.
  2. redirect: flush_if_id = 1; stall_if = 0; issue = 0; hazard_stall ignored (the ID instruction is wrong-path).
  3. hazard_stall: stall_if = 1; bubble_ex = 1; issue = 0.
  4. Otherwise: issue = id_valid.
- Advance when ~stall_in:
  - entry[1] <= issue ? {1, id_rd, id_rd_we, id_is_load} : 0.
  - entry[k] <= entry[k-1] for k = 2..DEPTH.
  - entry[DEPTH] retires; the regfile write is visible to ID on the following cycle, so a same-cycle entry-DEPTH match is forwarded.
- Counters: increment by 1 per qualifying cycle and saturate at all-ones (no wrap). redirect & hazard together counts as a flush only.
- busy = OR of entry valid bits.

Test Plan:
- DEPTH=3, FWD_EN=1: issue add x5, next ID add with rs1=5 -> fwd_rs1=1, stall_if=0, issue=1; one cycle later an ID reading x5 gets fwd_rs1=2.
- Load-use: issue lw x6, next ID rs2=6 -> stall_if=1, bubble_ex=1, stall_cnt=1 for one cycle; next cycle fwd_rs2=2, issue=1.
- x0 writer (rd=0, we=1) followed by a reader of rs1=0 -> fwd_rs1=0, no stall. rs2 match with rs2_used=0 -> no stall.
- redirect while ID has a load-use hazard -> flush_if_id=1, stall_if=0, bubble_ex=0, entry[1] invalid next cycle, flush_cnt +1, stall_cnt unchanged.
- stall_in held 3 cycles with 3 valid entries -> entries and fwd outputs frozen, issue=0, counters unchanged. FWD_EN=0 variant: rs1 matches entry 1 -> stall_if=1 for 3 cycles until retire, stall_cnt=3.
- Reset and saturation: sys_rst low with busy=1 -> next cycle busy=0, counters 0; with CNT_W=4 and 20 hazard cycles -> stall_cnt=15.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller for the in-order pipeline.
// Keeps a DEPTH-entry shadow of the post-ID stages (entry 1 = EX, entry DEPTH = WB).
// The shadow is used to pick forward sources and to detect stalls.
// Also produces stall/bubble/flush control and saturating performance counters.
module pipe_hazard_ctrl #(
    parameter int ADDR_W     = 5,
    parameter int DEPTH      = 3,
    parameter int FWD_EN     = 1,
    parameter int LOAD_STAGE = 2,
    parameter int CNT_W      = 16,
    localparam int SEL_W     = $clog2(DEPTH + 1)
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs1,
    input  logic              id_rs1_used,
    input  logic [ADDR_W-1:0] id_rs2,
    input  logic              id_rs2_used,
    input  logic [ADDR_W-1:0] id_rd,
    input  logic              id_rd_we,
    input  logic              id_is_load,
    input  logic              redirect,
    input  logic              stall_in,
    output logic              stall_if,
    output logic              bubble_ex,
    output logic              flush_if_id,
    output logic              issue,
    output logic [SEL_W-1:0]  fwd_rs1,
    output logic [SEL_W-1:0]  fwd_rs2,
    output logic              busy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic [DEPTH:1]    ent_valid;
    logic [DEPTH:1]    ent_we;
    logic [DEPTH:1]    ent_load;
    logic [ADDR_W-1:0] ent_rd [1:DEPTH];

    logic [SEL_W-1:0]  sel_rs1;
    logic [SEL_W-1:0]  sel_rs2;
    logic              hazard_rs1;
    logic              hazard_rs2;
    logic              hazard_stall;

    // Find the youngest matching writer per operand; scanning oldest-first lets the youngest overwrite.
    always_comb begin
        sel_rs1    = '0;
        sel_rs2    = '0;
        hazard_rs1 = 1'b0;
        hazard_rs2 = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (ent_valid[k] && ent_we[k] && (ent_rd[k] == id_rs1) &&
                (id_rs1 != '0) && id_rs1_used) begin
                sel_rs1    = SEL_W'(k);
                hazard_rs1 = (FWD_EN != 0) ? (ent_load[k] && (k < LOAD_STAGE)) : 1'b1;
            end
            if (ent_valid[k] && ent_we[k] && (ent_rd[k] == id_rs2) &&
                (id_rs2 != '0) && id_rs2_used) begin
                sel_rs2    = SEL_W'(k);
                hazard_rs2 = (FWD_EN != 0) ? (ent_load[k] && (k < LOAD_STAGE)) : 1'b1;
            end
        end
    end

    assign hazard_stall = id_valid && (hazard_rs1 || hazard_rs2);
    assign fwd_rs1      = (FWD_EN != 0) ? sel_rs1 : '0;
    assign fwd_rs2      = (FWD_EN != 0) ? sel_rs2 : '0;
    assign busy         = |ent_valid;

    // Pipeline control by priority: external freeze, then redirect, then hazard, then normal issue.
    always_comb begin
        stall_if    = 1'b0;
        bubble_ex   = 1'b0;
        flush_if_id = 1'b0;
        issue       = 1'b0;
        if (stall_in) begin
            stall_if = 1'b1;
        end else if (redirect) begin
            flush_if_id = 1'b1;
        end else if (hazard_stall) begin
            stall_if  = 1'b1;
            bubble_ex = 1'b1;
        end else begin
            issue = id_valid;
        end
    end

    // Shift the writer shadow one stage per unfrozen cycle; a non-issuing cycle inserts an empty entry.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            ent_valid <= '0;
            ent_we    <= '0;
            ent_load  <= '0;
            for (int k = 1; k <= DEPTH; k++) begin
                ent_rd[k] <= '0;
            end
        end else if (!stall_in) begin
            ent_valid[1] <= issue;
            ent_we[1]    <= issue && id_rd_we;
            ent_load[1]  <= issue && id_is_load;
            ent_rd[1]    <= issue ? id_rd : '0;
            for (int k = 2; k <= DEPTH; k++) begin
                ent_valid[k] <= ent_valid[k-1];
                ent_we[k]    <= ent_we[k-1];
                ent_load[k]  <= ent_load[k-1];
                ent_rd[k]    <= ent_rd[k-1];
            end
        end
    end

    // Saturating counters; a redirect that coincides with a hazard counts only as a flush.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (hazard_stall && !stall_in && !redirect && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush_if_id && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule
